// File: rtl/router_input_arbiter.sv
// Round-robin arbiter that lets several packet sources share one router input port.
// Each transaction: stream one packet, wait for the router to take it, drain, then hold the line idle.
module router_input_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_MAX  = 4096,
  parameter int GAP_CYC    = 2,
  parameter int MAX_LEN    = 2000,
  localparam int IW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_grant,
  output wire  [7:0]           rtr_dut_inp,
  output logic                 rtr_inp_valid,
  input  logic                 rtr_busy,
  input  logic [3:0]           rtr_error,
  output logic                 done_pulse,
  output logic [IW-1:0]        done_src,
  output logic [1:0]           done_status,
  output logic [3:0]           done_err,
  output logic [15:0]          pkt_count
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int DW = $clog2(DRAIN_MAX + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    XFER   = 3'd1,
    SETTLE = 3'd2,
    DRAIN  = 3'd3,
    GAP    = 3'd4
  } state_t;

  state_t        state_r;
  logic [IW-1:0] gsrc_r;
  logic [IW-1:0] ptr_r;
  logic [CW-1:0] byte_cnt_r;
  logic [SW-1:0] settle_cnt_r;
  logic [DW-1:0] drain_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic          aborted_r;
  logic [7:0]    data_r;

  logic [7:0]    sel_data_s;
  logic          sel_valid_s;
  logic          sel_last_s;
  logic [IW-1:0] pick_s;
  logic          fin_s;
  logic [1:0]    fin_status_s;

  // First requesting source at or after ptr, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            j;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j     = int'(ptr) + k;
      j     = (j >= NUM_SRC) ? (j - NUM_SRC) : j;
      pick  = (!found && req[j]) ? IW'(j) : pick;
      found = found | req[j];
    end
    return pick;
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
    return (idx == IW'(NUM_SRC - 1)) ? IW'(0) : (idx + IW'(1));
  endfunction

  // The line is only driven while a byte is valid.
  assign rtr_dut_inp = rtr_inp_valid ? data_r : 8'hzz;

  // Mux the granted source's byte stream and pick the next round-robin winner.
  always_comb begin
    sel_data_s  = 8'h00;
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data_s  = (gsrc_r == IW'(i)) ? src_data[8*i +: 8] : sel_data_s;
      sel_valid_s = (gsrc_r == IW'(i)) ? src_valid[i]       : sel_valid_s;
      sel_last_s  = (gsrc_r == IW'(i)) ? src_last[i]        : sel_last_s;
    end
    pick_s = rr_pick(src_req, ptr_r);
  end

  // Decide whether the current SETTLE/DRAIN cycle ends the transaction, and with which status.
  always_comb begin
    fin_s        = 1'b0;
    fin_status_s = 2'd0;
    case (state_r)
      SETTLE: begin
        if (!rtr_busy && (settle_cnt_r == SW'(SETTLE_CYC - 1))) begin
          fin_s        = 1'b1;
          fin_status_s = aborted_r ? 2'd2 : 2'd1;
        end else begin
          fin_s        = 1'b0;
        end
      end
      DRAIN: begin
        if (!rtr_busy) begin
          fin_s        = 1'b1;
          fin_status_s = aborted_r ? 2'd2 : 2'd0;
        end else if (drain_cnt_r == DW'(DRAIN_MAX - 1)) begin
          fin_s        = 1'b1;
          fin_status_s = 2'd3;
        end else begin
          fin_s        = 1'b0;
        end
      end
      default: begin
        fin_s        = 1'b0;
        fin_status_s = 2'd0;
      end
    endcase
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      src_grant     <= '0;
      rtr_inp_valid <= 1'b0;
      data_r        <= 8'h00;
      done_pulse    <= 1'b0;
      done_src      <= '0;
      done_status   <= 2'd0;
      done_err      <= 4'd0;
      pkt_count     <= 16'd0;
      ptr_r         <= '0;
      gsrc_r        <= '0;
      byte_cnt_r    <= '0;
      settle_cnt_r  <= '0;
      drain_cnt_r   <= '0;
      gap_cnt_r     <= '0;
      aborted_r     <= 1'b0;
    end else begin
      done_pulse    <= 1'b0;
      rtr_inp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (|src_req) begin
            gsrc_r     <= pick_s;
            ptr_r      <= next_idx(pick_s);
            src_grant  <= NUM_SRC'(1) << pick_s;
            byte_cnt_r <= '0;
            aborted_r  <= 1'b0;
            done_err   <= 4'd0;
            state_r    <= XFER;
          end
        end
        XFER: begin
          data_r        <= sel_data_s;
          rtr_inp_valid <= sel_valid_s;
          settle_cnt_r  <= '0;
          if (sel_valid_s) begin
            byte_cnt_r <= byte_cnt_r + CW'(1);
            if (sel_last_s) begin
              src_grant <= '0;
              state_r   <= SETTLE;
            end else if (byte_cnt_r == CW'(MAX_LEN - 1)) begin
              src_grant <= '0;
              aborted_r <= 1'b1;
              state_r   <= SETTLE;
            end
          end else if (byte_cnt_r != '0) begin
            // Stream broke mid-packet; an idle start before the first byte is tolerated.
            src_grant <= '0;
            aborted_r <= 1'b1;
            state_r   <= SETTLE;
          end
        end
        SETTLE: begin
          drain_cnt_r  <= '0;
          settle_cnt_r <= settle_cnt_r + SW'(1);
          if (rtr_error != 4'd0) begin
            done_err <= rtr_error;
          end
          if (rtr_busy) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt_r <= drain_cnt_r + DW'(1);
          if (rtr_error != 4'd0) begin
            done_err <= rtr_error;
          end
        end
        GAP: begin
          if (gap_cnt_r == GW'(GAP_CYC - 1)) begin
            state_r <= IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          src_grant <= '0;
        end
      endcase
      if (fin_s) begin
        state_r     <= GAP;
        gap_cnt_r   <= '0;
        done_pulse  <= 1'b1;
        done_src    <= gsrc_r;
        done_status <= fin_status_s;
        if (pkt_count != 16'hFFFF) begin
          pkt_count <= pkt_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_router_input_arbiter.sv
// Directed bench for router_input_arbiter: hand-computed expectations checked with immediate assertions.
module tb_router_input_arbiter;

  localparam int NS    = 4;
  localparam int SETTL = 4;
  localparam int DMAX  = 64;
  localparam int GAPC  = 2;
  localparam int MLEN  = 24;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NS-1:0]   src_req = '0;
  logic [8*NS-1:0] src_data = {NS{8'hEE}};
  logic [NS-1:0]   src_valid = '0;
  logic [NS-1:0]   src_last = '0;
  logic [NS-1:0]   src_grant;
  wire  [7:0]      rtr_dut_inp;
  logic            rtr_inp_valid;
  logic            rtr_busy = 1'b0;
  logic [3:0]      rtr_error = 4'd0;
  logic            done_pulse;
  logic [1:0]      done_src;
  logic [1:0]      done_status;
  logic [3:0]      done_err;
  logic [15:0]     pkt_count;

  int checks = 0;
  int failures = 0;
  int lat;

  router_input_arbiter #(
    .NUM_SRC(NS), .SETTLE_CYC(SETTL), .DRAIN_MAX(DMAX), .GAP_CYC(GAPC), .MAX_LEN(MLEN)
  ) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_data(src_data),
    .src_valid(src_valid), .src_last(src_last), .src_grant(src_grant),
    .rtr_dut_inp(rtr_dut_inp), .rtr_inp_valid(rtr_inp_valid), .rtr_busy(rtr_busy),
    .rtr_error(rtr_error), .done_pulse(done_pulse), .done_src(done_src),
    .done_status(done_status), .done_err(done_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bval(input int s, input int k);
    return 8'((s * 64 + k * 5 + 3) % 256);
  endfunction

  task automatic wait_grant(input int s);
    int i;
    i = 0;
    while (src_grant == '0 && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk("grant", 32'(src_grant), 32'(1) << s);
  endtask

  // Called at the negedge where the grant is visible; returns one negedge after the source goes quiet.
  task automatic send(input int s, input int n, input bit with_last, input int pre);
    for (int k = 0; k < pre; k++) begin
      @(negedge clk);
      chk("pre_idle_valid", 32'(rtr_inp_valid), 32'd0);
    end
    for (int k = 0; k < n; k++) begin
      src_data[8*s +: 8] = bval(s, k);
      src_valid[s]       = 1'b1;
      src_last[s]        = with_last && (k == n - 1);
      @(negedge clk);
      chk("byte_valid", 32'(rtr_inp_valid), 32'd1);
      chk("byte_data", 32'(rtr_dut_inp), 32'(bval(s, k)));
    end
    chk("grant_at_end", 32'(src_grant[s]), (with_last || n == MLEN) ? 32'd0 : 32'd1);
    src_valid[s]       = 1'b0;
    src_last[s]        = 1'b0;
    src_data[8*s +: 8] = 8'hEE;
    @(negedge clk);
    chk("valid_after_end", 32'(rtr_inp_valid), 32'd0);
    chk("grant_after_end", 32'(src_grant), 32'd0);
  endtask

  task automatic check_done(input int limit, input int e_src, input int e_stat,
                            input int e_err, input int e_cnt);
    lat = 0;
    while (!done_pulse && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", 32'(done_pulse), 32'd1);
    chk("done_src", 32'(done_src), 32'(e_src));
    chk("done_status", 32'(done_status), 32'(e_stat));
    chk("done_err", 32'(done_err), 32'(e_err));
    chk("pkt_count", 32'(pkt_count), 32'(e_cnt));
    @(negedge clk);
    chk("done_one_cycle", 32'(done_pulse), 32'd0);
  endtask

  initial begin
    int l_settle;
    int l_drain;

    // Reset values
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_grant", 32'(src_grant), 32'd0);
    chk("rst_valid", 32'(rtr_inp_valid), 32'd0);
    chk("rst_done", 32'(done_pulse), 32'd0);
    chk("rst_status", 32'(done_status), 32'd0);
    chk("rst_err", 32'(done_err), 32'd0);
    chk("rst_cnt", 32'(pkt_count), 32'd0);

    // Single 20-byte packet from source 0; request dropped once granted, busy for 30 cycles.
    src_req = 4'b0001;
    wait_grant(0);
    src_req = 4'b0000;
    send(0, 20, 1'b1, 0);
    rtr_busy = 1'b1;
    repeat (30) @(negedge clk);
    rtr_busy = 1'b0;
    check_done(20, 0, 0, 0, 1);

    // All sources requesting after reset: grants 0,1,2,3,0.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    src_req = 4'b1111;
    for (int p = 0; p < 5; p++) begin
      wait_grant(p % 4);
      if (p == 4) src_req = 4'b0000;
      send(p % 4, 3, 1'b1, 0);
      rtr_busy = 1'b1;
      repeat (3) @(negedge clk);
      rtr_busy = 1'b0;
      check_done(20, p % 4, 0, 0, p + 1);
    end

    // Router never busy, reports error 2: dropped after SETTLE_CYC cycles.
    src_req = 4'b0100;
    wait_grant(2);
    src_req = 4'b0000;
    send(2, 4, 1'b1, 0);
    rtr_error = 4'd2;
    check_done(20, 2, 1, 2, 6);
    l_settle = lat;
    chk("settle_latency", 32'(l_settle), 32'(SETTL - 1));
    rtr_error = 4'd0;

    // Source 1 idles two cycles, sends 7 bytes, then stops without last: aborted, error cleared.
    src_req = 4'b0010;
    wait_grant(1);
    src_req = 4'b0000;
    send(1, 7, 1'b0, 2);
    check_done(20, 1, 2, 0, 7);

    // Busy stuck high: drain timeout, then the pending request from source 0 is granted.
    src_req = 4'b1000;
    wait_grant(3);
    src_req = 4'b0000;
    send(3, 2, 1'b1, 0);
    rtr_busy = 1'b1;
    src_req  = 4'b0001;
    check_done(200, 3, 3, 0, 8);
    l_drain = lat;
    chk("drain_latency", 32'(l_drain), 32'(DMAX + 1));
    wait_grant(0);
    src_req  = 4'b0000;
    rtr_busy = 1'b0;

    // MAX_LEN bytes without last: forced end, aborted.
    send(0, MLEN, 1'b0, 0);
    check_done(20, 0, 2, 0, 9);

    // Reset during transfer after 5 bytes: everything back to reset values, next grant to source 0.
    src_req = 4'b0010;
    wait_grant(1);
    src_req = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      src_data[15:8] = bval(1, k);
      src_valid[1]   = 1'b1;
      @(negedge clk);
      chk("pre_reset_data", 32'(rtr_dut_inp), 32'(bval(1, k)));
    end
    reset = 1'b1;
    @(negedge clk);
    src_valid = '0;
    chk("mid_rst_grant", 32'(src_grant), 32'd0);
    chk("mid_rst_valid", 32'(rtr_inp_valid), 32'd0);
    chk("mid_rst_done", 32'(done_pulse), 32'd0);
    chk("mid_rst_src", 32'(done_src), 32'd0);
    chk("mid_rst_status", 32'(done_status), 32'd0);
    chk("mid_rst_cnt", 32'(pkt_count), 32'd0);
    reset = 1'b0;
    src_req = 4'b1111;
    wait_grant(0);
    chk("post_rst_done", 32'(done_pulse), 32'd0);
    chk("post_rst_cnt", 32'(pkt_count), 32'd0);
    src_req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
